// File: rtl/prefix_pkg.sv
// Shared types and constants for the Kogge-Stone prefix adder.
package prefix_pkg;

    // Default operand width; must be a power of two, at least 2.
    localparam int DEFAULT_WIDTH = 32;

    // Number of prefix levels for the default width.
    localparam int LEVELS = $clog2(DEFAULT_WIDTH);

    // Group generate / propagate pair carried through the prefix tree.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Prefix operator: merge a higher-order group with the adjacent lower one.
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/gp_cell.sv
// Black cell of the prefix tree: combines a high group with its low neighbour.
module gp_cell
    import prefix_pkg::*;
(
    input  gp_t hi,
    input  gp_t lo,
    output gp_t gp
);

    assign gp = gp_combine(hi, lo);

endmodule

// File: rtl/prefix_adder.sv
// Kogge-Stone parallel-prefix adder with carry-in, carry-out and one output
// register stage. No handshake: a new operation is accepted every cycle and
// its result is visible from the following rising edge until the next one.
module prefix_adder
    import prefix_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int TREE_LEVELS = $clog2(WIDTH);

    gp_t  [WIDTH-1:0] gp_pre;
    gp_t  [WIDTH-1:0] gp_final;
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    // Bitwise generate/propagate; cin is folded into bit 0 so the tree output
    // at position i is the group generate over [i:-1], i.e. the carry out of bit i.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            gp_pre[i].g = a[i] & b[i];
            gp_pre[i].p = a[i] ^ b[i];
        end
        gp_pre[0].g = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
        gp_pre[0].p = 1'b0;
    end

    // Prefix tree: level k merges each position with the one 2^k below it;
    // positions below 2^k already span down to -1 and pass through.
    for (genvar k = 0; k < TREE_LEVELS; k++) begin : g_level
        gp_t [WIDTH-1:0] lvl_in;
        gp_t [WIDTH-1:0] lvl_out;

        if (k == 0) begin : g_first
            assign lvl_in = gp_pre;
        end else begin : g_next
            assign lvl_in = g_level[k-1].lvl_out;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= (1 << k)) begin : g_cell
                gp_cell u_cell (
                    .hi (lvl_in[i]),
                    .lo (lvl_in[i-(1<<k)]),
                    .gp (lvl_out[i])
                );
            end else begin : g_pass
                assign lvl_out[i] = lvl_in[i];
            end
        end
    end

    assign gp_final = g_level[TREE_LEVELS-1].lvl_out;

    // Carries into each bit, the sum XOR and the carry out of the MSB.
    always_comb begin
        prop     = a ^ b;
        carry    = '0;
        carry[0] = cin;
        for (int i = 1; i < WIDTH; i++) begin
            carry[i] = gp_final[i-1].g;
        end
        sum_d  = prop ^ carry;
        cout_d = gp_final[WIDTH-1].g;
    end

    // Output register; reset clears the result immediately, independent of clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign s    = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_prefix_adder.sv
// Directed and random checks for prefix_adder (WIDTH = 32).
module tb_prefix_adder;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;

    logic [W:0]   exp_q[$];
    int           n_assert = 0;
    int           n_fail   = 0;

    // Clock and DUT
    always #5 clk = ~clk;

    prefix_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .s     (s),
        .cout  (cout)
    );

    // Compare {cout, s} against an expected value
    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one operation at a falling edge, check its result one edge later
    task automatic directed(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic cv, input logic exp_cout, input logic [W-1:0] exp_s);
        @(negedge clk);
        a   = av;
        b   = bv;
        cin = cv;
        @(negedge clk);
        check(tag, {cout, s}, {exp_cout, exp_s});
    endtask

    // Random driver: new operands each cycle, expected value queued
    task automatic drive_random();
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic         cv;
        av  = $urandom();
        bv  = $urandom();
        cv  = 1'($urandom_range(0, 1));
        a   = av;
        b   = bv;
        cin = cv;
        exp_q.push_back({1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv});
    endtask

    initial begin
        // Reset held with nonzero inputs
        rst_n = 1'b0;
        a     = 32'hFFFF_FFFF;
        b     = 32'h0000_0001;
        cin   = 1'b0;
        #2;
        check("reset_t0", {cout, s}, 33'h0_0000_0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hold", {cout, s}, 33'h0_0000_0000);

        // First edge after release registers the inputs already present
        rst_n = 1'b1;
        @(negedge clk);
        check("first_after_reset", {cout, s}, 33'h1_0000_0000);

        // Directed vectors
        directed("zero",       32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000);
        directed("one_plus_1", 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002);
        directed("ripple",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0000);
        directed("prop_cin0",  32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 32'hFFFF_FFFF);
        directed("prop_cin1",  32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b1, 32'h0000_0000);
        directed("mixed_cin",  32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, 32'h9999_999A);
        directed("all_ones",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFF);
        directed("cin_only",   32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001);
        directed("msb_carry",  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h0000_0000);
        directed("prop_mid",   32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000);

        // Mid-stream asynchronous reset, away from any rising edge
        directed("pre_reset",  32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 32'hFFFF_FFFF);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", {cout, s}, 33'h0_0000_0000);
        a   = 32'h0000_0001;
        b   = 32'h0000_0001;
        cin = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ignores_inputs", {cout, s}, 33'h0_0000_0000);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_mid_reset", {cout, s}, 33'h0_0000_0002);

        // Back-to-back random operands against a behavioral sum
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (exp_q.size() > 0) check("random", {cout, s}, exp_q.pop_front());
            drive_random();
        end
        @(negedge clk);
        check("random_last", {cout, s}, exp_q.pop_front());

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/prefix_adder.md
# prefix_adder

Pipelined 32-bit parallel-prefix (Kogge-Stone) adder with carry-in and carry-out. It is a reusable arithmetic leaf for datapaths that need a fast, fixed-latency add. The prefix tree is combinational and feeds a single output register stage, so the sum appears one clock after the operands are sampled.

## Interface
Parameters:
- WIDTH, default 32: operand and sum width. Must be a power of two, at least 2.

Ports (in this positional order):
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  WIDTH  addend A, unsigned or two's complement.
- b  input  WIDTH  addend B.
- cin  input  1  carry-in to bit 0.
- s  output  WIDTH  registered sum, (a + b + cin) mod 2^WIDTH.
- cout  output  1  registered carry-out of bit WIDTH-1.

One clock domain; reset is asynchronous assert, active-low.

## Operation
- Bitwise pre-processing: g[i] = a[i] & b[i], p[i] = a[i] ^ b[i].
- Carry-in handling:
  - cin is folded in as a generate at position -1, with G[-1] = cin and P[-1] = 0.
  - Equivalently, bit 0 uses G0 = g[0] | (p[0] & cin).
- Prefix tree:
  - Kogge-Stone, log2(WIDTH) levels (5 for WIDTH = 32).
  - Level k combines span 2^k: G = Gh | (Ph & Gl), P = Ph & Pl.
  - Positions without a partner at distance 2^k pass through unchanged.
- Carries: c[i] = group generate G[i-1:-1], i.e. the carry into bit i, with c[0] = cin.
- Sum: s_next[i] = p[i] ^ c[i].
- Carry-out: cout_next = G[WIDTH-1:-1].
- No overflow flag. Signed overflow is derivable externally from the MSBs.
- Full 2^(2·WIDTH+1) input space is legal. There are no invalid inputs and no X-propagation requirements beyond standard RTL semantics.

## Timing
- Latency: 1 cycle.
  - a, b and cin are sampled on the rising edge of clk.
  - s and cout show that result from that edge until the next edge.
- Throughput: one new operation per cycle. No handshake and no stall.
- Reset:
  - rst_n low asynchronously forces s = 0 and cout = 0, regardless of clk.
  - While rst_n is low, outputs hold 0 and inputs are ignored.
  - The first edge after rst_n deasserts registers the current inputs.
- Reset mid-stream: an operation sampled before the assert is lost, and the output shows 0 immediately.
- Combinational path: input to register is the pre-processing, 5 prefix levels and the sum XOR. There are no combinational input-to-output paths.

## Structure
- Shared package prefix_pkg:
  - Default WIDTH constant (32).
  - Localparam LEVELS = $clog2(WIDTH).
  - typedef gp_t, a struct of {logic g; logic p;}.
- Sub-module gp_cell (black cell) holds the prefix operator: inputs hi/lo gp_t, output gp_t.
  - The tree is built by generate loops over level and bit index, instantiating gp_cell or a pass-through.
- Top level contains pre-processing, the tree, sum XOR and one always_ff register for {cout, s} with async reset.

## Test plan
- Reset: hold rst_n = 0 with a = FFFFFFFF, b = 1 -> s = 00000000 and cout = 0. Assert rst_n mid-stream -> outputs drop to 0 without waiting for a clock edge.
- Trivial adds, one cycle after each edge:
  - a = 0, b = 0, cin = 0 -> s = 00000000, cout = 0.
  - a = 1, b = 1, cin = 0 -> s = 00000002, cout = 0.
- Full carry ripple: a = FFFFFFFF, b = 00000001, cin = 0 -> s = 00000000, cout = 1.
- Propagate-only path: a = AAAAAAAA, b = 55555555, cin = 0 -> s = FFFFFFFF, cout = 0. Same operands with cin = 1 -> s = 00000000, cout = 1.
- Carry-in cases:
  - a = 12345678, b = 87654321, cin = 1 -> s = 9999999A, cout = 0.
  - a = FFFFFFFF, b = FFFFFFFF, cin = 1 -> s = FFFFFFFF, cout = 1.
- Back-to-back random operands every cycle, 10k vectors, checked against a behavioral {cout, s} = a + b + cin delayed by one cycle.
